// File: rtl/ibr_pkg.sv
// Shared types and constants for the integer branch unit (ibr_unit, ibr_resolve).
// Data width is fixed build-wide by IBR_XLEN; the unit's XLEN parameter must match it.
package ibr_pkg;

    localparam int unsigned IBR_XLEN        = 32;
    localparam int unsigned IBR_MAX_LATENCY = 4;

    typedef enum logic [1:0] {
        U_NONE = 2'd0,
        U_BR   = 2'd1,
        U_JAL  = 2'd2,
        U_JALR = 2'd3
    } t_uop;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic [IBR_XLEN-1:0] pc;
        logic [31:0]         imm32;
        logic [2:0]          funct3;
        t_uop                uop;
    } t_uinstr;

    typedef struct packed {
        logic                valid;
        t_uinstr             uinstr;
        logic                tkn;
        logic [IBR_XLEN-1:0] tgt;
        logic [IBR_XLEN-1:0] result;
        logic                mispred;
        logic                misalign;
    } t_ibr_stage;

    typedef struct packed {
        logic                vld;
        logic [IBR_XLEN-1:0] tgt;
    } t_br_redirect;

    function automatic logic [IBR_XLEN-1:0] sext_imm(input logic [31:0] imm);
        return IBR_XLEN'($signed(imm));
    endfunction

endpackage

// File: rtl/ibr_resolve.sv
// Combinational EX0 branch resolution: condition compare, target, link value,
// mispredict and misalignment. valid marks a BR/JAL/JALR uop.
module ibr_resolve
    import ibr_pkg::*;
(
    input  t_uinstr             uinstr,
    input  logic [IBR_XLEN-1:0] src1val,
    input  logic [IBR_XLEN-1:0] src2val,
    input  logic                pred_tkn,
    input  logic [IBR_XLEN-1:0] pred_tgt,
    output t_ibr_stage          stage
);

    logic [IBR_XLEN-1:0] imm;
    logic [IBR_XLEN-1:0] pc_seq;
    logic [IBR_XLEN-1:0] br_tgt;
    logic [IBR_XLEN-1:0] jalr_sum;
    logic                cmp_tkn;

    assign imm      = sext_imm(uinstr.imm32);
    assign pc_seq   = uinstr.pc + IBR_XLEN'(4);
    assign br_tgt   = uinstr.pc + imm;
    assign jalr_sum = src1val + imm;

    always_comb begin
        case (uinstr.funct3)
            F3_BEQ:  cmp_tkn = (src1val == src2val);
            F3_BNE:  cmp_tkn = (src1val != src2val);
            F3_BLT:  cmp_tkn = ($signed(src1val) < $signed(src2val));
            F3_BGE:  cmp_tkn = ($signed(src1val) >= $signed(src2val));
            F3_BLTU: cmp_tkn = (src1val < src2val);
            F3_BGEU: cmp_tkn = (src1val >= src2val);
            default: cmp_tkn = 1'b0;
        endcase
    end

    always_comb begin
        stage        = '0;
        stage.uinstr = uinstr;
        case (uinstr.uop)
            U_BR: begin
                stage.valid = 1'b1;
                stage.tkn   = cmp_tkn;
                stage.tgt   = br_tgt;
            end
            U_JAL: begin
                stage.valid  = 1'b1;
                stage.tkn    = 1'b1;
                stage.tgt    = br_tgt;
                stage.result = pc_seq;
            end
            U_JALR: begin
                stage.valid  = 1'b1;
                stage.tkn    = 1'b1;
                stage.tgt    = jalr_sum & ~IBR_XLEN'(1);
                stage.result = pc_seq;
            end
            default: ;
        endcase
        stage.mispred  = (stage.tkn != pred_tkn) || (stage.tkn && (stage.tgt != pred_tgt));
        stage.misalign = stage.tkn && (stage.tgt[1:0] != 2'b00);
    end

endmodule

// File: rtl/ibr_unit.sv
// Pipelined branch/jump execution unit: LATENCY result stages, redirect handshake
// with wrong-path kill and stall. Optional statistics counters with IBR_STATS_EN.
module ibr_unit
    import ibr_pkg::*;
#(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned XLEN    = IBR_XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            valid_ex0,
    output logic            ready_ex0,
    input  t_uinstr         uinstr_ex0,
    input  logic [XLEN-1:0] src1val_ex0,
    input  logic [XLEN-1:0] src2val_ex0,
    input  logic            pred_tkn_ex0,
    input  logic [XLEN-1:0] pred_tgt_ex0,
    output logic            resvld_exn,
    output t_uinstr         uinstr_exn,
    output logic [XLEN-1:0] result_exn,
    output logic            misalign_exn,
    output logic            redirect_vld,
    output logic [XLEN-1:0] redirect_tgt,
    input  logic            redirect_rdy
`ifdef IBR_STATS_EN
    ,
    output logic [31:0]     stat_br_cnt,
    output logic [31:0]     stat_mp_cnt
`endif
);

    t_ibr_stage      ex0_stage;
    t_ibr_stage      fin;
    t_ibr_stage      pipe_q [LATENCY];
    t_br_redirect    redir_q;
    logic            accept;
    logic            set_now;
    logic            hold;
    logic [XLEN-1:0] fin_next_pc;

    ibr_resolve u_resolve (
        .uinstr   (uinstr_ex0),
        .src1val  (src1val_ex0),
        .src2val  (src2val_ex0),
        .pred_tkn (pred_tkn_ex0),
        .pred_tgt (pred_tgt_ex0),
        .stage    (ex0_stage)
    );

    assign fin         = pipe_q[LATENCY-1];
    assign fin_next_pc = fin.tkn ? fin.tgt : fin.uinstr.pc + XLEN'(4);
    assign set_now     = fin.valid && fin.mispred && !fin.misalign;

    // The redirect is visible in the resolving cycle; redir_q only carries it while fetch stalls.
    assign redirect_vld = redir_q.vld || set_now;
    assign redirect_tgt = set_now ? fin_next_pc : redir_q.tgt;
    assign hold         = redirect_vld && !redirect_rdy;
    assign ready_ex0    = !hold;
    assign accept       = valid_ex0 && ready_ex0 && !flush;

    assign resvld_exn   = fin.valid;
    assign uinstr_exn   = fin.uinstr;
    assign result_exn   = fin.result;
    assign misalign_exn = fin.valid && fin.misalign;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
            redir_q <= '0;
        end else begin
            if (flush) begin
                for (int i = 0; i < LATENCY; i++) pipe_q[i].valid <= 1'b0;
            end else if (set_now) begin
                // Mispredicting uop retires; everything younger, including EX0, is wrong-path.
                for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
            end else if (!hold) begin
                pipe_q[0] <= (accept && ex0_stage.valid) ? ex0_stage : '0;
                for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
            end

            if (set_now) redir_q.tgt <= fin_next_pc;

            if (flush)             redir_q.vld <= 1'b0;
            else if (set_now)      redir_q.vld <= !redirect_rdy;
            else if (redirect_rdy) redir_q.vld <= 1'b0;
        end
    end

`ifdef IBR_STATS_EN
    logic [31:0] br_cnt_q;
    logic [31:0] mp_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            br_cnt_q <= br_cnt_q + 32'(fin.valid);
            mp_cnt_q <= mp_cnt_q + 32'(set_now);
        end
    end

    assign stat_br_cnt = br_cnt_q;
    assign stat_mp_cnt = mp_cnt_q;

`ifdef SIMULATION
    always_ff @(posedge clk) begin
        if (!reset && fin.valid) begin
            $display("INFO ibr_unit: pc=%h tkn=%0d tgt=%h mispred=%0d misalign=%0d",
                     fin.uinstr.pc, fin.tkn, fin.tgt, fin.mispred, fin.misalign);
        end
    end
`endif
`endif

endmodule
